// File: rtl/qdec_updown.sv
// qdec_updown: quadrature decoder with wrapping up/down position counter.
// Raw A/B encoder phases are synchronized (SYNC_STAGES flops each), optionally
// glitch-filtered, then decoded into step/dir pulses that drive a WIDTH-bit
// position count. Two-bit phase jumps set a sticky err flag.
// Optional glitch filter: define QDEC_FILTER_EN to include it (FILT_LEN cycles).
module qdec_updown #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

`ifdef QDEC_FILTER_EN
  localparam int FILL_LEN = SYNC_STAGES + FILT_LEN;
`else
  localparam int FILL_LEN = SYNC_STAGES;
`endif
  localparam int FILL_W = $clog2(FILL_LEN + 1);

  if (SYNC_STAGES < 2 || FILT_LEN < 2) begin : g_bad_param
    $error("qdec_updown: SYNC_STAGES and FILT_LEN must both be >= 2");
  end

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [FILL_W-1:0]       fill_cnt, fill_d;

  logic [SYNC_STAGES-1:0]  a_sync, b_sync;
  logic [1:0]              ph_s;      // synchronized {A,B}
  logic [1:0]              cur_p;     // phase pair seen by the decoder
  logic [1:0]              prev_p;    // decoder phase pair from last cycle

  logic                    step_up, step_dn, illegal;

  // Two-flop (or deeper) synchronizer per phase input
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sync <= '0;
      b_sync <= '0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], a_in};
      b_sync <= {b_sync[SYNC_STAGES-2:0], b_in};
    end
  end

  assign ph_s = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

`ifdef QDEC_FILTER_EN
  localparam int FCNT_W = $clog2(FILT_LEN);

  logic [1:0]        ph_f;
  logic [FCNT_W-1:0] fcnt [2];

  // Glitch filter: accept a new phase level only after FILT_LEN stable cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      ph_f <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        fcnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (ph_s[i] != ph_f[i]) begin
          if (fcnt[i] == FCNT_W'(FILT_LEN - 1)) begin
            ph_f[i] <= ph_s[i];
            fcnt[i] <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + FCNT_W'(1);
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

  assign cur_p = ph_f;
`else
  assign cur_p = ph_s;
`endif

  // Previous-phase register follows the decoder input every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_p <= '0;
    end else begin
      prev_p <= cur_p;
    end
  end

  // FSM state and fill counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FILL;
      fill_cnt <= '0;
    end else begin
      state_q  <= state_d;
      fill_cnt <= fill_d;
    end
  end

  // FILL lasts one cycle beyond the pipeline depth so prev_p has caught up
  // with the settled decoder input before the first decode in RUN
  always_comb begin
    state_d = state_q;
    fill_d  = fill_cnt;
    case (state_q)
      FILL: begin
        if (fill_cnt == FILL_W'(FILL_LEN)) begin
          state_d = RUN;
        end else begin
          fill_d = fill_cnt + FILL_W'(1);
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // Decode {prev,cur} into up step, down step or illegal jump (RUN only)
  always_comb begin
    step_up = 1'b0;
    step_dn = 1'b0;
    illegal = 1'b0;
    if (state_q == RUN) begin
      case ({prev_p, cur_p})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_up = 1'b1;
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_dn = 1'b1;
        4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: illegal = 1'b1;
        default: ;
      endcase
    end
  end

  // Position, direction, step pulse and sticky error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      dir   <= 1'b1;
      step  <= 1'b0;
      err   <= 1'b0;
    end else begin
      step <= step_up | step_dn;

      if (clr) begin
        count <= '0;
      end else if (step_up) begin
        count <= count + WIDTH'(1);
      end else if (step_dn) begin
        count <= count - WIDTH'(1);
      end

      if (step_up) begin
        dir <= 1'b1;
      end else if (step_dn) begin
        dir <= 1'b0;
      end

      if (illegal) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule
